// File: rtl/banana_scan_ctrl_if.sv
// rtl/banana_scan_ctrl_if.sv - slot-config write port and pickup event channel
interface banana_scan_ctrl_if #(
  parameter int W = 16
);
  logic         cfg_we;
  logic [4:0]   cfg_idx;
  logic [W-1:0] cfg_x;
  logic [W-1:0] cfg_y;
  logic         evt_valid;
  logic [4:0]   evt_idx;
  logic         evt_ready;

  modport master (
    output cfg_we, cfg_idx, cfg_x, cfg_y, evt_ready,
    input  evt_valid, evt_idx
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_x, cfg_y, evt_ready,
    output evt_valid, evt_idx
  );
endinterface

// File: rtl/banana_scan_ctrl.sv
// rtl/banana_scan_ctrl.sv - per-frame banana pickup scanner, one slot per clock
// Optional feature macro: BANANA_LIFE_EN (count rolls over into an extra-life pulse).
module banana_scan_ctrl #(
  parameter int NUM_ITEMS   = 5,
  parameter int W           = 16,
  parameter int CNT_W       = 8,
  parameter int LIFE_THRESH = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start_i,
  input  logic                 level_restart_i,
  input  logic [W-1:0]         player_x_i,
  input  logic [W-1:0]         player_y_i,
  banana_scan_ctrl_if.slave    bus,
  output logic                 busy_o,
  output logic [NUM_ITEMS-1:0] present_mask_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 scan_done_o,
  output logic                 overrun_o,
  output logic                 life_pulse_o
);
  localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [4:0] LAST_IDX = 5'(NUM_ITEMS - 1);
  localparam logic signed [W+1:0] K16  = (W+2)'(16);
  localparam logic signed [W+1:0] K20  = (W+2)'(20);
  localparam logic signed [W+1:0] K80  = (W+2)'(80);
  localparam logic signed [W+1:0] K90  = (W+2)'(90);
  localparam logic signed [W+1:0] K110 = (W+2)'(110);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [W-1:0]         px_q, px_d, py_q, py_d;
  logic [W-1:0]         slot_x_q [NUM_ITEMS];
  logic [W-1:0]         slot_y_q [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] present_q, present_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W:0]       count_inc;
  logic                 evt_valid_q, evt_valid_d;
  logic [4:0]           evt_idx_q, evt_idx_d;
  logic                 overrun_q, overrun_d;
  logic                 cfg_ok, chan_free, hit, stall;
  logic signed [W+1:0]  px_s, py_s, sx_s, sy_s;
`ifdef BANANA_LIFE_EN
  logic                 life_q, life_d;
`endif

  // Zero-extended into W+2 signed bits so the offsets can neither wrap nor go negative-unsigned.
  assign px_s = $signed({2'b00, px_q});
  assign py_s = $signed({2'b00, py_q});
  assign sx_s = $signed({2'b00, slot_x_q[idx_q[IW-1:0]]});
  assign sy_s = $signed({2'b00, slot_y_q[idx_q[IW-1:0]]});
  assign hit  = (px_s + K90  <= sx_s + K16) && (px_s + K110 >= sx_s + K16) &&
                (py_s + K80  >= sy_s - K16) && (py_s + K20  <= sy_s - K16);

  assign chan_free = !evt_valid_q || bus.evt_ready;
  assign stall     = (state_q == SCAN) && hit && present_q[idx_q[IW-1:0]] && !chan_free;
  assign count_inc = {1'b0, count_q} + (CNT_W+1)'(1);
  assign cfg_ok    = (state_q == IDLE) && bus.cfg_we && ({1'b0, bus.cfg_idx} < 6'(NUM_ITEMS));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    px_d        = px_q;
    py_d        = py_q;
    present_d   = present_q;
    count_d     = count_q;
    evt_valid_d = evt_valid_q && !bus.evt_ready;
    evt_idx_d   = evt_idx_q;
    overrun_d   = overrun_q;
`ifdef BANANA_LIFE_EN
    life_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          px_d    = player_x_i;
          py_d    = player_y_i;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (frame_start_i) overrun_d = 1'b1;
        if (hit && present_q[idx_q[IW-1:0]] && chan_free) begin
          present_d[idx_q[IW-1:0]] = 1'b0;
          evt_valid_d = 1'b1;
          evt_idx_d   = idx_q;
`ifdef BANANA_LIFE_EN
          if (count_inc == (CNT_W+1)'(LIFE_THRESH)) begin
            count_d = '0;
            life_d  = 1'b1;
          end else begin
            count_d = count_inc[CNT_W-1:0];
          end
`else
          if (!count_inc[CNT_W]) count_d = count_inc[CNT_W-1:0];
`endif
        end
        if (!stall) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 5'd1;
        end
      end
      DONE: begin
        if (frame_start_i) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (level_restart_i) begin
      state_d     = IDLE;
      present_d   = '1;
      count_d     = '0;
      evt_valid_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef BANANA_LIFE_EN
      life_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      present_q   <= '1;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        slot_x_q[i] <= '0;
        slot_y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      px_q        <= px_d;
      py_q        <= py_d;
      present_q   <= present_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      evt_idx_q   <= evt_idx_d;
      overrun_q   <= overrun_d;
      if (cfg_ok) begin
        slot_x_q[bus.cfg_idx[IW-1:0]] <= bus.cfg_x;
        slot_y_q[bus.cfg_idx[IW-1:0]] <= bus.cfg_y;
      end
    end
  end

`ifdef BANANA_LIFE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) life_q <= 1'b0;
    else       life_q <= life_d;
  end
  assign life_pulse_o = life_q;
`else
  assign life_pulse_o = 1'b0;
`endif

  assign busy_o         = (state_q != IDLE);
  assign scan_done_o    = (state_q == DONE);
  assign present_mask_o = present_q;
  assign count_o        = count_q;
  assign overrun_o      = overrun_q;
  assign bus.evt_valid  = evt_valid_q;
  assign bus.evt_idx    = evt_idx_q;
endmodule

// File: tb/tb_banana_scan_ctrl.sv
// tb/tb_banana_scan_ctrl.sv - directed vector bench for banana_scan_ctrl
module tb_banana_scan_ctrl;
  localparam int N = 5, W = 16, CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start, level_restart;
  logic [W-1:0]  player_x, player_y;
  logic          busy, scan_done, overrun, life_pulse;
  logic [N-1:0]  present_mask;
  logic [CW-1:0] count;

  banana_scan_ctrl_if #(.W(W)) bus ();

  banana_scan_ctrl #(.NUM_ITEMS(N), .W(W), .CNT_W(CW), .LIFE_THRESH(3)) dut (
    .clk(clk), .reset(reset), .frame_start_i(frame_start), .level_restart_i(level_restart),
    .player_x_i(player_x), .player_y_i(player_y), .bus(bus), .busy_o(busy),
    .present_mask_o(present_mask), .count_o(count), .scan_done_o(scan_done),
    .overrun_o(overrun), .life_pulse_o(life_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [15:0] px, py, sx, sy;
    logic        hit;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [4:0] idx, input logic [15:0] x, input logic [15:0] y);
    bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_x = x; bus.cfg_y = y;
    tick;
    bus.cfg_we = 1'b0;
  endtask

  task automatic restart;
    level_restart = 1'b1;
    tick;
    level_restart = 1'b0;
  endtask

  task automatic run_scan(output int done_cyc);
    int cyc;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    cyc = 1;
    while (scan_done !== 1'b1 && cyc < 100) begin
      tick;
      cyc++;
    end
    if (scan_done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_timeout: got no scan_done after %0d cycles", cyc);
    end
    done_cyc = cyc;
    tick;
  endtask

  initial begin
    logic [9:0] busy_v, done_v;
    int cyc, evt_cnt, life_cnt;

    // Slot edge is sx+16=962 (X in 852..872) and sy-16=239 (Y in 159..219).
    vecs[0]  = '{"base_hit",   16'd860,   16'd200, 16'd946,   16'd255, 1'b1};
    vecs[1]  = '{"x_lo_edge",  16'd872,   16'd200, 16'd946,   16'd255, 1'b1};
    vecs[2]  = '{"x_lo_out",   16'd873,   16'd200, 16'd946,   16'd255, 1'b0};
    vecs[3]  = '{"x_hi_edge",  16'd852,   16'd200, 16'd946,   16'd255, 1'b1};
    vecs[4]  = '{"x_hi_out",   16'd851,   16'd200, 16'd946,   16'd255, 1'b0};
    vecs[5]  = '{"y_lo_edge",  16'd860,   16'd159, 16'd946,   16'd255, 1'b1};
    vecs[6]  = '{"y_lo_out",   16'd860,   16'd158, 16'd946,   16'd255, 1'b0};
    vecs[7]  = '{"y_hi_edge",  16'd860,   16'd219, 16'd946,   16'd255, 1'b1};
    vecs[8]  = '{"y_hi_out",   16'd860,   16'd220, 16'd946,   16'd255, 1'b0};
    vecs[9]  = '{"x_no_wrap",  16'd65440, 16'd200, 16'd65530, 16'd255, 1'b1};
    vecs[10] = '{"y_neg_slot", 16'd860,   16'd0,   16'd946,   16'd5,   1'b0};

    reset = 1'b1; frame_start = 1'b0; level_restart = 1'b0;
    player_x = '0; player_y = '0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_x = '0; bus.cfg_y = '0; bus.evt_ready = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;

    check("rst_present", present_mask, 5'b11111);
    check("rst_count", count, 0);
    check("rst_evt_valid", bus.evt_valid, 0);
    check("rst_evt_idx", bus.evt_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_life", life_pulse, 0);

    for (int i = 0; i < 11; i++) begin
      restart;
      write_slot(5'd0, vecs[i].sx, vecs[i].sy);
      player_x = vecs[i].px; player_y = vecs[i].py;
      run_scan(cyc);
      check({vecs[i].name, "_present0"}, present_mask[0], !vecs[i].hit);
      check({vecs[i].name, "_count"}, count, vecs[i].hit ? 1 : 0);
      check({vecs[i].name, "_done_cyc"}, cyc, 6);
    end

    // Unstalled latency with the consumer holding off.
    restart;
    write_slot(5'd0, 16'd946, 16'd255);
    player_x = 16'd860; player_y = 16'd200;
    bus.evt_ready = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    busy_v = '0; done_v = '0;
    for (int c = 1; c <= 7; c++) begin
      busy_v[c] = busy;
      done_v[c] = scan_done;
      if (c == 2) begin
        check("lat_present", present_mask, 5'b11110);
        check("lat_count", count, 1);
        check("lat_evt_valid", bus.evt_valid, 1);
        check("lat_evt_idx", bus.evt_idx, 0);
      end
      if (c < 7) tick;
    end
    check("lat_busy_cycles", busy_v, 10'b0001111110);
    check("lat_done_cycles", done_v, 10'b0001000000);
    check("lat_evt_held", bus.evt_valid, 1);
    bus.evt_ready = 1'b1;
    tick;
    check("lat_evt_accepted", bus.evt_valid, 0);

    // Ready held high: one-cycle event, then a rescan finds nothing new.
    restart;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    evt_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.evt_valid === 1'b1) evt_cnt++;
      tick;
    end
    check("rdy_evt_cycles", evt_cnt, 1);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    evt_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.evt_valid === 1'b1) evt_cnt++;
      tick;
    end
    check("rescan_evt_cycles", evt_cnt, 0);
    check("rescan_count", count, 1);

    // Two hits in a row with the consumer stalling the second for 3 cycles.
    restart;
    write_slot(5'd1, 16'd1335, 16'd270);
    write_slot(5'd2, 16'd1340, 16'd270);
    player_x = 16'd1250; player_y = 16'd200;
    bus.evt_ready = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    done_v = '0;
    for (int c = 1; c <= 9; c++) begin
      done_v[c] = scan_done;
      if (c == 3) begin
        check("stall_evt1_valid", bus.evt_valid, 1);
        check("stall_evt1_idx", bus.evt_idx, 1);
      end
      if (c == 5) check("stall_evt1_stable", {bus.evt_valid, bus.evt_idx}, {1'b1, 5'd1});
      if (c == 7) check("stall_evt2", {bus.evt_valid, bus.evt_idx}, {1'b1, 5'd2});
      if (c == 8) check("stall_evt2_drop", bus.evt_valid, 0);
      bus.evt_ready = (c >= 6);
      tick;
    end
    check("stall_done_cycle", done_v, 10'b1000000000);
    check("stall_count", count, 2);
    check("stall_present", present_mask, 5'b11001);

    // frame_start during a scan, then level_restart clears game state.
    restart;
    player_x = 16'd860; player_y = 16'd200;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    tick;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_busy", busy, 1);
    check("ovr_count_before", count, 1);
    level_restart = 1'b1;
    tick;
    level_restart = 1'b0;
    check("lr_busy", busy, 0);
    check("lr_overrun", overrun, 0);
    check("lr_present", present_mask, 5'b11111);
    check("lr_count", count, 0);
    check("lr_evt_valid", bus.evt_valid, 0);

    // level_restart wins over a simultaneous frame_start.
    level_restart = 1'b1; frame_start = 1'b1;
    tick;
    level_restart = 1'b0; frame_start = 1'b0;
    check("prio_busy0", busy, 0);
    tick;
    check("prio_busy1", busy, 0);
    check("prio_done", scan_done, 0);

    // Four pickups in one scan; a config write mid-scan must be ignored.
    restart;
    for (int s = 0; s < 4; s++) write_slot(5'(s), 16'd946, 16'd255);
    write_slot(5'd4, 16'd0, 16'd0);
    bus.evt_ready = 1'b1;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    life_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      if (life_pulse === 1'b1) life_cnt++;
      bus.cfg_we = (c == 2); bus.cfg_idx = 5'd4; bus.cfg_x = 16'd946; bus.cfg_y = 16'd255;
      tick;
    end
    bus.cfg_we = 1'b0;
    check("multi_present", present_mask, 5'b10000);
`ifdef BANANA_LIFE_EN
    check("multi_count", count, 1);
    check("multi_life_pulses", life_cnt, 1);
`else
    check("multi_count_sat", count, 3);
    check("multi_life_pulses", life_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
